axo_wb_sched: RTL

Writeback scheduler and register scoreboard for the integer regfile (32 x XLEN, dual-read, single-write, x0 hardwired zero, write on posedge clk when we=1).
- Arbitrates the single regfile write port between three producers: ALU (src 0), LSU (src 1) and CSR unit (src 2).
- Tracks in-flight destination registers.
- Stalls issue on RAW and WAW hazards.
- Sits between the decode/issue stage and the regfile write port.

---
 rtl/axo_wb_sched.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/axo_wb_sched.sv
// axo_wb_sched: writeback scheduler and register scoreboard for the integer
// regfile (32 x XLEN, dual-read, single-write, x0 hardwired to zero).
//
// Three producers share the single regfile write port: ALU (src 0),
// LSU (src 1) and CSR (src 2). Arbitration is round-robin. A 32-bit
// scoreboard tracks in-flight destinations so that issue stalls on RAW/WAW
// hazards.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   iss_valid/has_*/rs*/rd    instruction presented by the issue stage
//   iss_stall                 combinational: instruction must not issue
//   src_valid/rd/data         per-source writeback requests (packed)
//   src_ready                 combinational one-hot grant
//   rf_we/rf_rd/rf_din        registered regfile write port
//   pending                   scoreboard, bit 0 always 0
//   err                       sticky spurious-writeback flag
//
// Optional feature: define AXO_WB_CHECK_EN to flag (and report) writebacks
// to a register that is not pending. Without it err is tied to 0.

module axo_wb_sched #(
    parameter int unsigned XLEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                iss_valid,
    input  logic                iss_has_rs1,
    input  logic                iss_has_rs2,
    input  logic                iss_has_rd,
    input  logic [4:0]          iss_rs1,
    input  logic [4:0]          iss_rs2,
    input  logic [4:0]          iss_rd,
    output logic                iss_stall,
    input  logic [2:0]          src_valid,
    input  logic [14:0]         src_rd,
    input  logic [3*XLEN-1:0]   src_data,
    output logic [2:0]          src_ready,
    output logic                rf_we,
    output logic [4:0]          rf_rd,
    output logic [XLEN-1:0]     rf_din,
    output logic [31:0]         pending,
    output logic                err
);

    localparam int unsigned NSRC = 3;
    localparam int unsigned RW   = 5;

    logic [31:0]     pending_q, pending_d;
    logic [1:0]      rr_last_q, rr_last_d;
    logic            rf_we_q, rf_we_d;
    logic [RW-1:0]   rf_rd_q, rf_rd_d;
    logic [XLEN-1:0] rf_din_q, rf_din_d;

    logic            hazard;
    logic            issue_set;
    logic            gnt_vld;
    logic [1:0]      gnt_idx;
    logic [1:0]      cand;
    logic [RW-1:0]   gnt_rd;
    logic [XLEN-1:0] gnt_data;

    // Hazard detection; pending_q[0] is never set so x0 never stalls.
    always_comb begin
        hazard = (iss_has_rs1 & pending_q[iss_rs1])
               | (iss_has_rs2 & pending_q[iss_rs2])
               | (iss_has_rd  & pending_q[iss_rd]);
        iss_stall = rst | hazard;
        issue_set = iss_valid & ~iss_stall & iss_has_rd & (iss_rd != 5'd0);
    end

    // Round-robin search starting after the last granted source.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = 2'd0;
        cand    = 2'd0;
        for (int k = 1; k <= int'(NSRC); k++) begin
            cand = 2'((32'(rr_last_q) + 32'(k)) % 32'(NSRC));
            if (!gnt_vld && src_valid[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // Grant vector and selected payload.
    always_comb begin
        src_ready = '0;
        gnt_rd    = '0;
        gnt_data  = '0;
        for (int i = 0; i < int'(NSRC); i++) begin
            if (gnt_vld && (gnt_idx == 2'(i))) begin
                gnt_rd   = src_rd[RW*i +: RW];
                gnt_data = src_data[XLEN*i +: XLEN];
                if (!rst) begin
                    src_ready[i] = 1'b1;
                end
            end
        end
    end

    // Next-state: scoreboard clear from the write stage, set from issue.
    // The set is applied last so it wins on a same-index collision.
    always_comb begin
        pending_d = pending_q;
        rr_last_d = rr_last_q;
        rf_we_d   = 1'b0;
        rf_rd_d   = rf_rd_q;
        rf_din_d  = rf_din_q;
        if (rf_we_q) begin
            pending_d[rf_rd_q] = 1'b0;
        end
        if (issue_set) begin
            pending_d[iss_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
        if (gnt_vld) begin
            rf_we_d   = (gnt_rd != 5'd0);
            rf_rd_d   = gnt_rd;
            rf_din_d  = gnt_data;
            rr_last_d = gnt_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            rr_last_q <= 2'd2;
            rf_we_q   <= 1'b0;
            rf_rd_q   <= '0;
            rf_din_q  <= '0;
        end else begin
            pending_q <= pending_d;
            rr_last_q <= rr_last_d;
            rf_we_q   <= rf_we_d;
            rf_rd_q   <= rf_rd_d;
            rf_din_q  <= rf_din_d;
        end
    end

`ifdef AXO_WB_CHECK_EN
    logic err_q, err_d;
    logic spurious;

    // A grant to a non-zero rd that the scoreboard does not hold is spurious.
    always_comb begin
        spurious = gnt_vld & (gnt_rd != 5'd0) & ~pending_q[gnt_rd];
        err_d    = err_q | spurious;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
            if (spurious) begin
                $display("axo_wb_sched: spurious writeback src=%0d rd=%0d", gnt_idx, gnt_rd);
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign pending = pending_q;
    assign rf_we   = rf_we_q;
    assign rf_rd   = rf_rd_q;
    assign rf_din  = rf_din_q;

endmodule
